// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: turns an 8259 INTR into the two-pulse INTA# cycle,
// captures the vector byte and offers it to the execution unit. Optional bus lock: INTA_LOCK_EN.
`timescale 1ns/1ps

module inta_sequencer #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr,
    input  logic       if_en,
    input  logic [7:0] d_in,
    input  logic       vec_ack,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy,
    output logic       lock_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       intr_m;
    logic       intr_s;
    logic       start;

    // NOTE: intr comes from another timing domain; only the second flop may feed logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_m <= 1'b0;
            intr_s <= 1'b0;
        end else begin
            intr_m <= intr;
            intr_s <= intr_m;
        end
    end

    assign start = (state == S_IDLE) && intr_s && if_en;

    // NOTE: inta_n is a flop updated on the same edge as state, so the 8259 never sees a decode glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            inta_n       <= 1'b1;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_P1;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                    end
                end
                S_P1: begin
                    if (cnt == 4'd0) begin
                        state  <= S_GAP;
                        cnt    <= GAP_LD;
                        inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 4'd0) begin
                        state  <= S_P2;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_P2: begin
                    if (cnt == 4'd0) begin
                        state        <= S_HOLD;
                        inta_n       <= 1'b1;
                        vector       <= d_in;
                        vector_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (vec_ack) begin
                        state        <= S_IDLE;
                        vector_valid <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= 4'd0;
                    inta_n <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

`ifdef INTA_LOCK_EN
    // Lock spans the whole acknowledge pair: falls with the first pulse, rises with the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_n <= 1'b1;
        end else if (start) begin
            lock_n <= 1'b0;
        end else if ((state == S_P2) && (cnt == 4'd0)) begin
            lock_n <= 1'b1;
        end
    end
`else
    assign lock_n = 1'b1;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed scenarios plus a randomized run,
// all compared against a cycle-level phase model of the acknowledge sequence.
`timescale 1ns/1ps

module tb_inta_sequencer;

    localparam int P   = 2;
    localparam int G   = 3;
    localparam int SEQ = 2 * P + G;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr;
    logic       if_en;
    logic [7:0] d_in;
    logic       vec_ack;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       busy;
    logic       lock_n;

    int vectors     = 0;
    int miscompares = 0;

    inta_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk          (clk),
        .rst          (rst),
        .intr         (intr),
        .if_en        (if_en),
        .d_in         (d_in),
        .vec_ack      (vec_ack),
        .inta_n       (inta_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .busy         (busy),
        .lock_n       (lock_n)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence is "edges since start" m_t; pulses and capture follow from m_t.
    bit         m_busy  = 1'b0;
    int         m_t     = 0;
    logic [7:0] m_vec   = 8'h00;
    bit         m_valid = 1'b0;
    bit         h1      = 1'b0;
    bit         h2      = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_t = 0; m_vec = 8'h00; m_valid = 1'b0; h1 = 1'b0; h2 = 1'b0;
        end else begin
            if (!m_busy) begin
                if (h2 && if_en) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                end
            end else if (m_t < SEQ) begin
                m_t++;
                if (m_t == SEQ) begin
                    m_vec   = d_in;
                    m_valid = 1'b1;
                end
            end else if (vec_ack) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
            h2 = h1;
            h1 = intr;
        end
    end

    function automatic logic [11:0] expect_out();
        logic pulse;
        logic lock;
        pulse = m_busy && ((m_t < P) || ((m_t >= P + G) && (m_t < SEQ)));
`ifdef INTA_LOCK_EN
        lock = !(m_busy && (m_t < SEQ));
`else
        lock = 1'b1;
`endif
        return {!pulse, m_busy, m_valid, lock, m_vec};
    endfunction

    wire [11:0] dut_out = {inta_n, busy, vector_valid, lock_n, vector};

    task automatic test_reset();
        rst = 1'b1; intr = 1'b0; if_en = 1'b0; vec_ack = 1'b0; d_in = 8'hA5;
        repeat (3) @(negedge clk);
        vectors++;
        if ({inta_n, lock_n, vector, vector_valid, busy} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got inta_n=%b lock_n=%b vector=%h valid=%b busy=%b",
                     inta_n, lock_n, vector, vector_valid, busy);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL reset_idle got %h expected %h", dut_out, expect_out());
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp_inta;
        logic [9:0] exp_lock;
        exp_inta = 10'b1100111001;
`ifdef INTA_LOCK_EN
        exp_lock = 10'b1100000001;
`else
        exp_lock = 10'b1111111111;
`endif
        if_en = 1'b1; intr = 1'b1; d_in = 8'($urandom) | 8'h80;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (inta_n !== exp_inta[9-i] || lock_n !== exp_lock[9-i]) begin
                miscompares++;
                $display("FAIL basic_wave edge+%0d got inta_n=%b lock_n=%b expected %b %b",
                         i, inta_n, lock_n, exp_inta[9-i], exp_lock[9-i]);
            end
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL basic_model edge+%0d got %h expected %h", i, dut_out, expect_out());
            end
            d_in = (i >= 6) ? 8'h0A : (8'($urandom) | 8'h80);
            if (i == 9) intr = 1'b0;
        end
        repeat (5) begin
            d_in = 8'($urandom);
            @(negedge clk);
            vectors++;
            if (vector !== 8'h0A || vector_valid !== 1'b1 || inta_n !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_hold got vector=%h valid=%b inta_n=%b expected 0a 1 1",
                         vector, vector_valid, inta_n);
            end
        end
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        vectors++;
        if (vector_valid !== 1'b0 || busy !== 1'b0 || vector !== 8'h0A) begin
            miscompares++;
            $display("FAIL basic_ack got valid=%b busy=%b vector=%h expected 0 0 0a",
                     vector_valid, busy, vector);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_if_en_gate();
        if_en = 1'b0; intr = 1'b1;
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (inta_n !== 1'b1 || busy !== 1'b0 || dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL if_en_gate got inta_n=%b busy=%b out=%h expected 1 0 %h",
                         inta_n, busy, dut_out, expect_out());
            end
        end
        if_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (inta_n !== 1'b0) begin
            miscompares++;
            $display("FAIL if_en_start got inta_n=%b expected 0", inta_n);
        end
        intr = 1'b0;
        for (int i = 0; i < SEQ + 2; i++) begin
            d_in = 8'($urandom);
            if (i == SEQ) vec_ack = 1'b1;
            @(negedge clk);
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL if_en_seq step %0d got %h expected %h", i, dut_out, expect_out());
            end
        end
        vec_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_intr_drop();
        logic [7:0] d;
        d = 8'($urandom);
        intr = 1'b1; if_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL intr_drop step %0d got %h expected %h", i, dut_out, expect_out());
            end
            if (i == 4) intr = 1'b0;
            d_in = (i >= 6) ? d : ~d;
        end
        vectors++;
        if (vector !== d || vector_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL intr_drop_capture got vector=%h valid=%b expected %h 1", vector, vector_valid, d);
        end
        vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        intr = 1'b1; if_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_in = 8'($urandom) | 8'h01;
            @(negedge clk);
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL reset_mid step %0d got %h expected %h", i, dut_out, expect_out());
            end
        end
        rst = 1'b1; intr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({inta_n, vector, vector_valid, busy, lock_n} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid_values got inta_n=%b vector=%h valid=%b busy=%b lock_n=%b",
                     inta_n, vector, vector_valid, busy, lock_n);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold_stall();
        int falls;
        intr = 1'b1; if_en = 1'b1; d_in = 8'($urandom) | 8'h80;
        repeat (10) @(negedge clk);
        falls = 0;
        repeat (50) begin
            @(negedge clk);
            if (inta_n === 1'b0) falls++;
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL hold_model got %h expected %h", dut_out, expect_out());
            end
        end
        vectors++;
        if (falls != 0 || vector_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_stall got %0d low samples valid=%b expected 0 1", falls, vector_valid);
        end
        vec_ack = 1'b1; d_in = 8'h0C;
        @(negedge clk);
        vec_ack = 1'b0;
        vectors++;
        if (busy !== 1'b0 || vector_valid !== 1'b0 || inta_n !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_ack got busy=%b valid=%b inta_n=%b expected 0 0 1", busy, vector_valid, inta_n);
        end
        @(negedge clk);
        vectors++;
        if (inta_n !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_restart got inta_n=%b busy=%b expected 0 1", inta_n, busy);
        end
        repeat (SEQ) @(negedge clk);
        vectors++;
        if (vector !== 8'h0C || vector_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_second_capture got vector=%h valid=%b expected 0c 1", vector, vector_valid);
        end
        intr = 1'b0; vec_ack = 1'b1;
        @(negedge clk);
        vec_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) intr = ~intr;
            if_en   = ($urandom_range(0, 9) != 0);
            vec_ack = ($urandom_range(0, 3) == 0);
            d_in    = 8'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            vectors++;
            if (dut_out !== expect_out()) begin
                miscompares++;
                $display("FAIL random cycle %0d got %h expected %h", i, dut_out, expect_out());
            end
        end
        rst = 1'b0; intr = 1'b0; vec_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_if_en_gate();
        test_intr_drop();
        test_reset_mid();
        test_hold_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
